// File: rtl/rs232_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs232_pkg
// Description : Constants shared by the RS-232 receiver, transmitter and
//               receive FIFO blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package rs232_pkg;

    // Width of one serial character
    localparam int RS232_DATA_W              = 8;

    // Default log2 depth of the receive FIFO (16 bytes)
    localparam int RS232_FIFO_DEPTH_LOG2_DEF = 4;

endpackage : rs232_pkg
`default_nettype wire

// File: rtl/rs232_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : rs232_fifo_mem
// Description : Simple dual-port storage for the RS-232 receive FIFO.
//               One synchronous write port, one asynchronous read port,
//               contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_fifo_mem
    import rs232_pkg::*;
#(
    parameter int ADDR_W = RS232_FIFO_DEPTH_LOG2_DEF,
    parameter int DATA_W = RS232_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int c_WORDS = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [0:c_WORDS-1];

    // Write port: store one byte per enabled clock edge
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read port is combinational so the head byte falls through immediately
    assign rdata = r_mem[raddr];

endmodule : rs232_fifo_mem
`default_nettype wire

// File: rtl/rs232_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rs232_rx_fifo
// Description : Receive FIFO between an RS-232 receiver (rdy/done handshake)
//               and a CPU read port (first-word fall-through).
//               Optional macro RS232_RX_OVERRUN_EN: a byte arriving while the
//               FIFO is full (and not being popped) is acknowledged, dropped
//               and flags a sticky overrun. Without it the byte is left held
//               in the receiver until space frees up.
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_rx_fifo
    import rs232_pkg::*;
#(
    parameter int DEPTH_LOG2 = RS232_FIFO_DEPTH_LOG2_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_rdy,
    input  logic [RS232_DATA_W-1:0] rx_data,
    output logic                    rx_done,
    input  logic                    rd,
    output logic [RS232_DATA_W-1:0] rdata,
    output logic                    avail,
    output logic                    full,
    output logic [DEPTH_LOG2:0]     count,
    output logic                    ovf,
    input  logic                    ovf_clr
);

    localparam logic [DEPTH_LOG2:0] c_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_rx_done;

    logic w_take;
    logic w_pop;
    logic w_accept;
    logic w_drop;
    logic w_we;

    // Status flags come straight from the registered occupancy
    assign avail   = (r_count != '0);
    assign full    = (r_count == c_DEPTH);
    assign count   = r_count;
    assign rx_done = r_rx_done;

    // Handshake decode: a byte is only taken once, even though the receiver
    // still shows rdy during the acknowledge cycle
    always_comb begin
        w_take   = rx_rdy & ~r_rx_done;
        w_pop    = rd & avail;
        w_accept = w_take & (~full | w_pop);
`ifdef RS232_RX_OVERRUN_EN
        w_drop   = w_take & full & ~w_pop;
`else
        w_drop   = 1'b0;
`endif
    end

    // No writes land in storage while reset is being applied
    assign w_we = w_accept & ~rst;

    // Pointer, occupancy and acknowledge registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_rx_done <= 1'b0;
        end else begin
            r_rx_done <= w_accept | w_drop;
            if (w_accept) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef RS232_RX_OVERRUN_EN
    logic r_ovf;

    // Sticky overrun: a new drop wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`else
    // Overrun detection is not built; the clear input has no effect
    logic w_unused_ovf_clr;
    assign w_unused_ovf_clr = ovf_clr;
    assign ovf              = 1'b0;
`endif

    rs232_fifo_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (RS232_DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wptr),
        .wdata (rx_data),
        .raddr (r_rptr),
        .rdata (rdata)
    );

endmodule : rs232_rx_fifo
`default_nettype wire

// File: tb/tb_rs232_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs232_rx_fifo
// Description : Directed self-checking bench for rs232_rx_fifo (depth 16).
//               Covers both builds of RS232_RX_OVERRUN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs232_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rd;
    logic [7:0] rdata;
    logic       avail;
    logic       full;
    logic [4:0] count;
    logic       ovf;
    logic       ovf_clr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rs232_rx_fifo #(
        .DEPTH_LOG2 (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_rdy  (rx_rdy),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .rd      (rd),
        .rdata   (rdata),
        .avail   (avail),
        .full    (full),
        .count   (count),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a byte and hold it until acknowledged (bounded wait)
    task automatic push(input logic [7:0] b);
        int n;
        n       = 0;
        rx_rdy  = 1'b1;
        rx_data = b;
        do begin
            tick();
            n++;
        end while (!rx_done && n < 20);
        rx_rdy = 1'b0;
        chk("push_ack", {31'b0, rx_done}, 32'd1);
    endtask

    task automatic pop(output logic [7:0] d);
        chk("pop_avail", {31'b0, avail}, 32'd1);
        d  = rdata;
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        logic [7:0] d;
        pop(d);
        chk(tag, {24'b0, d}, {24'b0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         model;
        int         exp_b;
        logic       seen;

        rst     = 1'b1;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        rd      = 1'b0;
        ovf_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_avail",   {31'b0, avail},   32'd0);
        chk("rst_full",    {31'b0, full},    32'd0);
        chk("rst_count",   {27'b0, count},   32'd0);
        chk("rst_rx_done", {31'b0, rx_done}, 32'd0);
        chk("rst_ovf",     {31'b0, ovf},     32'd0);

        // Single byte: latency, single acknowledge pulse, pop
        rx_rdy  = 1'b1;
        rx_data = 8'h5A;
        chk("single_done_N", {31'b0, rx_done}, 32'd0);
        tick();
        chk("single_done_N1", {31'b0, rx_done}, 32'd1);
        chk("single_avail",   {31'b0, avail},   32'd1);
        chk("single_rdata",   {24'b0, rdata},   32'h5A);
        chk("single_count",   {27'b0, count},   32'd1);
        tick();
        chk("single_done_N2", {31'b0, rx_done}, 32'd0);
        chk("single_no_dup",  {27'b0, count},   32'd1);
        rx_rdy = 1'b0;
        pop_chk("single_pop", 8'h5A);
        chk("single_empty", {31'b0, avail}, 32'd0);
        chk("single_cnt0",  {27'b0, count}, 32'd0);

        // Order and wrap: 40 bytes, occupancy held at or below 10
        model = 0;
        exp_b = 0;
        for (int i = 0; i < 40; i++) begin
            push(8'(i));
            model++;
            chk("wrap_cnt", {27'b0, count}, 32'(model));
            if (model == 10) begin
                for (int k = 0; k < 4; k++) begin
                    pop_chk("wrap_order", 8'(exp_b));
                    exp_b++;
                    model--;
                end
            end
        end
        while (model > 0) begin
            pop_chk("wrap_order", 8'(exp_b));
            exp_b++;
            model--;
        end
        chk("wrap_total", 32'(exp_b), 32'd40);
        chk("wrap_empty", {27'b0, count}, 32'd0);

        // Fill to capacity
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        chk("fill_full",  {31'b0, full},  32'd1);
        chk("fill_count", {27'b0, count}, 32'd16);

`ifdef RS232_RX_OVERRUN_EN
        // Overrun: byte acknowledged and dropped, sticky flag
        push(8'hAA);
        chk("ovr_ovf",   {31'b0, ovf},   32'd1);
        chk("ovr_count", {27'b0, count}, 32'd16);
        tick();
        rx_rdy  = 1'b1;
        rx_data = 8'hBB;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovr_clr_drop_done", {31'b0, rx_done}, 32'd1);
        chk("ovr_clr_drop_ovf",  {31'b0, ovf},     32'd1);
        rx_rdy  = 1'b0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovr_cleared", {31'b0, ovf}, 32'd0);
        for (int i = 0; i < 16; i++) pop_chk("ovr_drain", 8'(8'h10 + i));
        chk("ovr_empty", {27'b0, count}, 32'd0);
`else
        // Full without overrun: byte held, taken once space frees
        rx_rdy  = 1'b1;
        rx_data = 8'hAA;
        ovf_clr = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | rx_done;
        end
        ovf_clr = 1'b0;
        chk("hold_no_ack", {31'b0, seen},  32'd0);
        chk("hold_count",  {27'b0, count}, 32'd16);
        chk("hold_ovf",    {31'b0, ovf},   32'd0);
        chk("hold_head",   {24'b0, rdata}, 32'h10);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("hold_ack",   {31'b0, rx_done}, 32'd1);
        chk("hold_cnt16", {27'b0, count},   32'd16);
        rx_rdy = 1'b0;
        for (int i = 1; i < 16; i++) pop_chk("hold_drain", 8'(8'h10 + i));
        pop_chk("hold_last", 8'hAA);
        chk("hold_empty", {27'b0, count}, 32'd0);
`endif

        // Simultaneous pop and accept while full
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        tick();
        chk("sim_head_before", {24'b0, rdata}, 32'h40);
        rd      = 1'b1;
        rx_rdy  = 1'b1;
        rx_data = 8'h77;
        tick();
        rd = 1'b0;
        chk("sim_count", {27'b0, count},   32'd16);
        chk("sim_done",  {31'b0, rx_done}, 32'd1);
        chk("sim_head",  {24'b0, rdata},   32'h41);
        rx_rdy = 1'b0;
        for (int i = 1; i < 16; i++) pop_chk("sim_drain", 8'(8'h40 + i));
        pop_chk("sim_last", 8'h77);

        // Simultaneous rd and byte while empty: only the accept happens
        rd      = 1'b1;
        rx_rdy  = 1'b1;
        rx_data = 8'h99;
        tick();
        rd     = 1'b0;
        rx_rdy = 1'b0;
        chk("empty_sim_count", {27'b0, count}, 32'd1);
        chk("empty_sim_rdata", {24'b0, rdata}, 32'h99);
        pop_chk("empty_sim_pop", 8'h99);

        // Reset mid-stream and mid-acknowledge
        for (int i = 1; i <= 5; i++) push(8'(i));
        tick();
        chk("mid_count5", {27'b0, count}, 32'd5);
        rx_rdy  = 1'b1;
        rx_data = 8'h33;
        tick();
        chk("mid_ack", {31'b0, rx_done}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_avail", {31'b0, avail},   32'd0);
        chk("mid_rst_count", {27'b0, count},   32'd0);
        chk("mid_rst_ovf",   {31'b0, ovf},     32'd0);
        chk("mid_rst_done",  {31'b0, rx_done}, 32'd0);
        chk("mid_rst_full",  {31'b0, full},    32'd0);
        tick();
        rx_rdy = 1'b0;
        chk("mid_new_done",  {31'b0, rx_done}, 32'd1);
        chk("mid_new_count", {27'b0, count},   32'd1);
        pop_chk("mid_new_byte", 8'h33);
        chk("mid_sole", {31'b0, avail}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rs232_rx_fifo
`default_nettype wire

// File: doc/rs232_rx_fifo.md
RS232_RX_FIFO -- requirements
Module: rs232_rx_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, log2 of FIFO depth (16 bytes); legal range 2..8.
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst  input  1  reset is synchronous and active-high.
REQ-004 rx_rdy  input  1  byte available from upstream RS-232 receiver, held until acknowledged.
REQ-005 rx_data  input  8  received byte, valid while rx_rdy=1.
REQ-006 rx_done  output  1  one-cycle acknowledge to receiver ("byte has been read").
REQ-007 rd  input  1  CPU pop strobe, one cycle per byte.
REQ-008 rdata  output  8  head-of-FIFO byte, first-word fall-through.
REQ-009 avail  output  1  FIFO non-empty.
REQ-010 full  output  1  FIFO holds 2^DEPTH_LOG2 bytes.
REQ-011 count  output  DEPTH_LOG2+1  current occupancy.
REQ-012 ovf  output  1  sticky overrun flag (see Configuration).
REQ-013 ovf_clr  input  1  clears ovf.

Function
REQ-014 take = rx_rdy & ~rx_done; rx_done SHALL be registered: rx_done <= take & (accept | drop), so no byte is taken twice while the receiver's rdy is still high in the acknowledge cycle.
REQ-015 accept = take & (~full | pop); pop = rd & avail; full evaluated from pre-edge state.
REQ-016 On accept, rx_data SHALL be written at mem[wptr], wptr increments modulo depth at the same edge.
REQ-017 On pop, rptr increments modulo depth; rd while empty SHALL be ignored (no pointer/count change).
REQ-018 count: +1 on accept only, -1 on pop only, unchanged on both or neither; never exceeds depth or underflows.
REQ-019 avail = (count != 0); full = (count == depth); both derived from registered count.
REQ-020 Latency: byte with rx_rdy rising in cycle N SHALL appear on rdata with avail=1 in cycle N+1; rx_done high in cycle N+1 only.
REQ-021 rdata = mem[rptr] combinationally; value undefined while avail=0.
REQ-022 Pop and accept in the same cycle while full: both SHALL occur, count stays at depth, oldest byte removed, new byte stored.
REQ-023 Pop and accept in the same cycle while empty: only accept occurs (pop gated by avail).
REQ-024 Pointers SHALL wrap silently; data order SHALL be preserved across wrap.

Reset
REQ-025 rst=1 at an edge SHALL clear wptr, rptr, count, rx_done, ovf; avail=0, full=0 in the following cycle.
REQ-026 Storage array SHALL NOT be reset.
REQ-027 Reset mid-acknowledge: rx_done SHALL be 0 after reset edge; a byte held on rx_rdy afterwards SHALL be taken as new.

Configuration
REQ-028 Macro RS232_RX_OVERRUN_EN, when defined: take while full without pop = drop; rx_done pulses, byte discarded, ovf set; ovf cleared by ovf_clr; ovf_clr and new drop same cycle SHALL leave ovf=1.
REQ-029 Macro RS232_RX_OVERRUN_EN undefined: take while full without pop SHALL NOT assert rx_done (byte stays held in receiver); ovf tied 0; ovf_clr ignored.

Structure
REQ-030 Package rs232_pkg SHALL hold RS232_DATA_W=8 and RS232_FIFO_DEPTH_LOG2_DEF=4, shared with receiver/transmitter blocks.
REQ-031 Storage SHALL be sub-module rs232_fifo_mem (1 write, 1 async read port, no reset); pointer/count/handshake logic in rs232_rx_fifo.

Verification
REQ-032 Single byte: rx_rdy=1, rx_data=0x5A held until rx_done -> rx_done one pulse in N+1, avail=1, rdata=0x5A, count=1; rd -> avail=0, count=0.
REQ-033 Fill/order/wrap: 40 bytes 0x00..0x27 pushed with interleaved pops keeping count <= 10 -> read sequence exactly 0x00..0x27, count never > 10.
REQ-034 Full with macro: 16 bytes 0x10..0x1F, then 0xAA -> rx_done pulses, ovf=1, count=16, reads return 0x10..0x1F; ovf_clr -> ovf=0.
REQ-035 Full without macro: 16 bytes, then 0xAA held -> rx_done stays 0; rd once -> 0xAA accepted next cycle, count=16, last read after drain = 0xAA.
REQ-036 Simultaneous: full FIFO, rd and new byte 0x77 same cycle -> count stays 16, head advances, 0x77 is last byte out.
REQ-037 Reset mid-stream: count=5, assert rst one cycle -> avail=0, count=0, ovf=0, rx_done=0; next byte 0x33 read back as sole entry.
